scroll_lanes: RTL and testbench
===============================

// Module: scroll_lanes
// PURPOSE
//   Multi-lane horizontal scroll engine, successor to the single-lane scroller.
//   One shared move-tick prescaler drives N independent lane position counters.
//   Each lane has its own step size and direction, and wraps modulo SPAN.
//   Tick period shortens with score down to a floor. Feeds the obstacle/lane
//   renderers, which consume h_pos and use tick as their "move followers" strobe.
// PARAMETERS
//   N_LANES        4       number of lanes
//   POS_W          10      lane position width
//   SPAN           640     wrap modulus in pixels; positions lie in 0..SPAN-1
//   STEP_W         3       per-lane step width; every step must be < SPAN
//   SCORE_W        7       score input width
//   CTR_W          18      prescaler width; must hold PERIOD
//   PERIOD         100000  base cycles per tick (4 ms @ 25 MHz)
//   SPEEDUP_SHIFT  8       period reduction per score = score << SPEEDUP_SHIFT
//   MIN_PERIOD     20000   floor on the effective period; must be >= 1
// PORTS
//   clk       input   1                clock
//   reset     input   1                synchronous, active-high
//   enable    input   1                1 = run, 0 = pause (freeze all state)
//   score     input   SCORE_W          current score; sets the speed
//   lane_step input   N_LANES*STEP_W   per-lane step; lane i at [i*STEP_W +: STEP_W]
//   lane_dir  input   N_LANES          per lane: 0 = right (+step), 1 = left (-step)
//   h_pos     output  N_LANES*POS_W    lane positions; lane i at [i*POS_W +: POS_W]
//   tick      output  1                1-cycle pulse in the cycle positions update
//   wrap      output  N_LANES          per-lane 1-cycle pulse, coincident with tick
// BEHAVIOUR
//   - Reset (highest priority, overrides enable): ctr=0, h_pos all 0, tick=0,
//     wrap=0. Reset mid-count leaves no residual or pending tick.
//   - eff = PERIOD - (score << SPEEDUP_SHIFT)
//       - compute eff in CTR_W+1 bits;
//       - if the result is negative or < MIN_PERIOD, eff = MIN_PERIOD.
//     eff is combinational from score.
//   - enable=1 and ctr >= eff-1:
//       - ctr <= 0;
//       - tick <= 1;
//       - every lane updates on the same edge.
//     Otherwise, with enable=1: ctr <= ctr+1, tick <= 0, wrap <= 0.
//     Ticks are therefore exactly eff cycles apart at constant score.
//   - Score change mid-count is compared immediately against the new eff. If
//     ctr already >= new eff-1, tick fires on the next edge (no underflow).
//   - enable=0: ctr and h_pos hold, tick=0, wrap=0. On resume the count
//     continues from the held ctr value.
//   - Lane update, computed in POS_W+1 bits with s = step, p = pos:
//       right: n = p+s;  if n >= SPAN then p <= n-SPAN, wrap=1;  else p <= n.
//       left:  if p < s then p <= p+SPAN-s, wrap=1;  else p <= p-s.
//     Wrap keeps the remainder; it never snaps to 0.
//   - step=0: the lane holds and never wraps.
//   - Inputs lane_step and lane_dir are sampled on the tick edge only. They may
//     change at any time without glitching h_pos.
//   - All outputs are registered. Latency from counter terminal to new h_pos
//     and tick is 1 edge.
// STRUCTURE
//   - Package scroll_pkg holds: SPAN, default PERIOD, MIN_PERIOD and
//     SPEEDUP_SHIFT, and the lane direction constants DIR_RIGHT=0, DIR_LEFT=1.
//   - Sub-module scroll_tick_gen: prescaler plus eff clamp. Inputs are clk,
//     reset, enable and score; output is tick_next.
//   - Per-lane update logic sits in a generate loop inside scroll_lanes.
// TESTING (bench overrides: PERIOD=10, MIN_PERIOD=4, SPEEDUP_SHIFT=1, SPAN=640)
//   1. Reset, then enable=1, score=0, lane0 step=2 right -> tick every 10 cycles;
//      lane0 reads 0,2,4,... and wrap stays 0.
//   2. lane1 step=3 right, run 213 ticks -> pos 639; next tick -> pos 2,
//      wrap[1]=1 for 1 cycle, coincident with tick.
//   3. lane2 step=2 left from 0 -> first tick pos 638 with wrap[2]=1;
//      next tick 636 with wrap[2]=0.
//   4. score=3 -> ticks 4 cycles apart (10-6).
//      score=5 -> eff 0, clamped to 4.
//      score=127 -> 4 (negative eff clamped).
//      Score dropped 0->3 when ctr=7 -> tick on the next edge.
//   5. enable=0 for 25 cycles at ctr=6 -> no tick, h_pos frozen. After
//      re-enable, tick fires 4 cycles later.
//   6. Assert reset at ctr=5 with lanes nonzero -> next cycle all h_pos=0,
//      tick=0, wrap=0. First tick comes 10 cycles after release.
//      lane3 step=0 -> never moves, never wraps.

Source files
------------

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared constants and lane direction encoding for the lane scroller
package scroll_pkg;
    localparam int SPAN = 640;
    localparam int PERIOD = 100000;
    localparam int MIN_PERIOD = 20000;
    localparam int SPEEDUP_SHIFT = 8;
    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;
endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: score-scaled move-tick prescaler with a floor on the period
module scroll_tick_gen #(
    parameter int SCORE_W = 7,
    parameter int CTR_W = 18,
    parameter int PERIOD = scroll_pkg::PERIOD,
    parameter int SPEEDUP_SHIFT = scroll_pkg::SPEEDUP_SHIFT,
    parameter int MIN_PERIOD = scroll_pkg::MIN_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [SCORE_W-1:0] score,
    output logic               tick_next
);
    localparam int EW = CTR_W + 1;
    logic [CTR_W-1:0] ctr;
    logic [EW-1:0] diff, eff;
    // the extra top bit of diff is the sign: a huge score drives it negative
    assign diff = EW'(PERIOD) - (EW'(score) << SPEEDUP_SHIFT);
    assign eff = (diff[EW-1] || diff < EW'(MIN_PERIOD)) ? EW'(MIN_PERIOD) : diff;
    assign tick_next = enable && ({1'b0, ctr} >= eff - EW'(1));
    always_ff @(posedge clk) begin
        if (reset)
            ctr <= '0;
        else if (enable)
            ctr <= tick_next ? '0 : ctr + CTR_W'(1);
    end
endmodule

// File: rtl/scroll_lanes.sv
// scroll_lanes: N independent wrap-around lane position counters on one shared move tick
module scroll_lanes #(
    parameter int N_LANES = 4,
    parameter int POS_W = 10,
    parameter int SPAN = scroll_pkg::SPAN,
    parameter int STEP_W = 3,
    parameter int SCORE_W = 7,
    parameter int CTR_W = 18,
    parameter int PERIOD = scroll_pkg::PERIOD,
    parameter int SPEEDUP_SHIFT = scroll_pkg::SPEEDUP_SHIFT,
    parameter int MIN_PERIOD = scroll_pkg::MIN_PERIOD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [SCORE_W-1:0]        score,
    input  logic [N_LANES*STEP_W-1:0] lane_step,
    input  logic [N_LANES-1:0]        lane_dir,
    output logic [N_LANES*POS_W-1:0]  h_pos,
    output logic                      tick,
    output logic [N_LANES-1:0]        wrap
);
    localparam logic [POS_W:0] SPAN_X = (POS_W+1)'(SPAN);
    logic tick_next;
    logic [POS_W-1:0] pos [N_LANES];
    logic [POS_W-1:0] pos_nxt [N_LANES];
    logic [N_LANES-1:0] lane_wrap;

    scroll_tick_gen #(
        .SCORE_W(SCORE_W),
        .CTR_W(CTR_W),
        .PERIOD(PERIOD),
        .SPEEDUP_SHIFT(SPEEDUP_SHIFT),
        .MIN_PERIOD(MIN_PERIOD)
    ) u_tick (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .score(score),
        .tick_next(tick_next)
    );

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [POS_W:0] p, s, sum;
        logic left;
        assign p = {1'b0, pos[g]};
        assign s = (POS_W+1)'(lane_step[g*STEP_W +: STEP_W]);
        assign sum = p + s;
        assign left = lane_dir[g] == scroll_pkg::DIR_LEFT;
        // wrapping keeps the overshoot, so motion stays smooth across the seam
        assign lane_wrap[g] = left ? (p < s) : (sum >= SPAN_X);
        assign pos_nxt[g] = left ? (lane_wrap[g] ? POS_W'(p + SPAN_X - s) : POS_W'(p - s))
                                 : (lane_wrap[g] ? POS_W'(sum - SPAN_X) : POS_W'(sum));
        assign h_pos[g*POS_W +: POS_W] = pos[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= 1'b0;
            wrap <= '0;
            for (int i = 0; i < N_LANES; i++) pos[i] <= '0;
        end else begin
            tick <= tick_next;
            wrap <= tick_next ? lane_wrap : '0;
            if (tick_next)
                for (int i = 0; i < N_LANES; i++) pos[i] <= pos_nxt[i];
        end
    end
endmodule

// File: tb/tb_scroll_lanes.sv
// tb_scroll_lanes: directed tables and sequences plus randomized checking against a modulo-arithmetic model
module tb_scroll_lanes;
    localparam int NL = 4, PW = 10, SW = 3, SPAN = 640, PER = 10, MINP = 4, SH = 1;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [6:0] score = '0;
    logic [NL*SW-1:0] lane_step = '0;
    logic [NL-1:0] lane_dir = '0;
    logic [NL*PW-1:0] h_pos;
    logic tick;
    logic [NL-1:0] wrap;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    scroll_lanes #(
        .N_LANES(NL), .POS_W(PW), .SPAN(SPAN), .STEP_W(SW), .SCORE_W(7), .CTR_W(18),
        .PERIOD(PER), .SPEEDUP_SHIFT(SH), .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .score(score),
        .lane_step(lane_step), .lane_dir(lane_dir),
        .h_pos(h_pos), .tick(tick), .wrap(wrap)
    );

    // reference: elapsed enabled cycles since the last tick, positions kept modulo SPAN
    int m_cnt = 0;
    int m_pos [NL];
    bit m_tick = 1'b0;
    bit [NL-1:0] m_wrap = '0;
    initial foreach (m_pos[i]) m_pos[i] = 0;

    always @(posedge clk) begin
        int eff, s;
        eff = PER - (int'(score) << SH);
        if (eff < MINP) eff = MINP;
        if (reset) begin
            m_cnt = 0; m_tick = 0; m_wrap = '0;
            foreach (m_pos[i]) m_pos[i] = 0;
        end else if (!enable) begin
            m_tick = 0; m_wrap = '0;
        end else if (m_cnt + 1 >= eff) begin
            m_cnt = 0; m_tick = 1;
            for (int i = 0; i < NL; i++) begin
                s = int'(lane_step[i*SW +: SW]);
                if (lane_dir[i]) begin
                    m_wrap[i] = s > m_pos[i];
                    m_pos[i] = (m_pos[i] - s + SPAN) % SPAN;
                end else begin
                    m_wrap[i] = m_pos[i] + s >= SPAN;
                    m_pos[i] = (m_pos[i] + s) % SPAN;
                end
            end
        end else begin
            m_cnt++; m_tick = 0; m_wrap = '0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos(input int i);
        return int'(h_pos[i*PW +: PW]);
    endfunction

    task automatic set_lane(input int i, input int s, input bit d);
        lane_step[i*SW +: SW] = SW'(s);
        lane_dir[i] = d;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 300);
    endtask

    typedef struct {
        int score;
        int interval;
    } rate_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rate_t rates [7];
        int n, bad;
        logic [NL*PW-1:0] saved;
        rates = '{'{0, 10}, '{1, 8}, '{2, 6}, '{3, 4}, '{4, 4}, '{5, 4}, '{127, 4}};

        // reset state, then lane0 stepping right
        repeat (2) @(negedge clk);
        chk("reset_hpos", h_pos, 0);
        chk("reset_tick", tick, 0);
        chk("reset_wrap", wrap, 0);
        reset = 0; enable = 1;
        set_lane(0, 2, 0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(n);
            chk("t1_interval", n, 10);
            chk("t1_lane0", pos(0), 2 * k);
            chk("t1_wrap", wrap, 0);
        end
        @(negedge clk);
        chk("t1_tick_one_cycle", tick, 0);

        // lane1 right wrap keeps the remainder
        set_lane(0, 0, 0);
        set_lane(1, 3, 0);
        for (int k = 0; k < 213; k++) wait_tick(n);
        chk("t2_lane1_639", pos(1), 639);
        chk("t2_no_wrap", wrap[1], 0);
        wait_tick(n);
        chk("t2_lane1_2", pos(1), 2);
        chk("t2_wrap1", wrap[1], 1);
        chk("t2_tick", tick, 1);
        @(negedge clk);
        chk("t2_wrap1_clear", wrap[1], 0);
        set_lane(1, 0, 0);

        // lane2 left from zero
        set_lane(2, 2, 1);
        wait_tick(n);
        chk("t3_lane2_638", pos(2), 638);
        chk("t3_wrap2", wrap[2], 1);
        wait_tick(n);
        chk("t3_lane2_636", pos(2), 636);
        chk("t3_wrap2_clear", wrap[2], 0);
        set_lane(2, 0, 0);

        // tick spacing versus score, including clamps
        foreach (rates[r]) begin
            score = 7'(rates[r].score);
            wait_tick(n);
            wait_tick(n);
            chk($sformatf("t4_interval_score%0d", rates[r].score), n, rates[r].interval);
        end
        score = 0;
        wait_tick(n);
        wait_tick(n);
        repeat (7) @(negedge clk);
        score = 3;
        @(negedge clk);
        chk("t4_score_drop_tick", tick, 1);

        // pause freezes everything, count resumes from the held value
        score = 0;
        set_lane(0, 5, 0);
        wait_tick(n);
        repeat (6) @(negedge clk);
        saved = h_pos;
        enable = 0;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (tick || h_pos != saved || wrap != 0) bad++;
        end
        chk("t5_pause_frozen", bad, 0);
        enable = 1;
        wait_tick(n);
        chk("t5_resume_interval", n, 4);

        // reset mid-count
        set_lane(3, 0, 1);
        wait_tick(n);
        repeat (5) @(negedge clk);
        chk("t6_lanes_nonzero", h_pos != 0, 1);
        reset = 1;
        @(negedge clk);
        chk("t6_reset_hpos", h_pos, 0);
        chk("t6_reset_tick", tick, 0);
        chk("t6_reset_wrap", wrap, 0);
        reset = 0;
        wait_tick(n);
        chk("t6_first_interval", n, 10);
        chk("t6_lane0", pos(0), 5);
        chk("t6_lane3_still", pos(3), 0);
        chk("t6_lane3_nowrap", wrap[3], 0);

        // randomized inputs against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_tick", tick, m_tick);
            chk("rnd_wrap", wrap, m_wrap);
            for (int i = 0; i < NL; i++) chk($sformatf("rnd_lane%0d", i), pos(i), m_pos[i]);
            reset = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0)
                score = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 5));
            lane_step = NL*SW'($urandom);
            lane_dir = NL'($urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
